// File: rtl/sys_array_job_dispatcher_if.sv
// Job descriptor port of the systolic-array job dispatcher.
// Valid/ready handshake carrying one comp or load job per beat.
interface sys_array_job_dispatcher_if;
  logic        job_valid;
  logic        job_ready;
  logic        job_is_load;
  logic        job_bank;
  logic [15:0] job_addr0;
  logic [15:0] job_addr1;
  logic [15:0] job_addr2;

  modport master (
    output job_valid,
    output job_is_load,
    output job_bank,
    output job_addr0,
    output job_addr1,
    output job_addr2,
    input  job_ready
  );

  modport slave (
    input  job_valid,
    input  job_is_load,
    input  job_bank,
    input  job_addr0,
    input  job_addr1,
    input  job_addr2,
    output job_ready
  );
endinterface

// File: rtl/sys_array_job_dispatcher.sv
// Systolic-array job dispatcher: in-order FIFO feeding comp and load
// lock channels, with bank conflict blocking and sticky error flags.
module sys_array_job_dispatcher #(
  parameter int FIFO_DEPTH    = 4,
  parameter int GRANT_TIMEOUT = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  sys_array_job_dispatcher_if.slave job,
  output logic [1:0]               comp_lock_req,
  output logic [1:0][15:0]         A_addr,
  output logic [1:0][15:0]         D_addr,
  output logic [1:0][15:0]         C_addr,
  input  logic [1:0]               comp_lock_res,
  input  logic                     comp_finished,
  output logic [1:0]               load_lock_req,
  output logic [1:0][15:0]         b_addr,
  input  logic [1:0]               load_lock_res,
  input  logic                     load_finished,
  output logic                     idle,
  output logic [15:0]              done_count,
  output logic                     err_protocol,
  output logic                     err_timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(GRANT_TIMEOUT + 1);

  typedef struct packed {
    logic        is_load;
    logic        bank;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] a2;
  } job_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RUN,
    S_REL
  } st_t;

  job_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  job_t          head;

  st_t             st    [2];
  logic            bk    [2];
  logic [CW-1:0]   cnt   [2];
  logic [1:0]      req_q [2];
  logic [1:0][15:0] a_q  [2];
  logic [1:0][15:0] d_q;
  logic [1:0][15:0] c_q;

  logic [1:0] fin;
  logic [1:0] res_hit;
  logic [1:0] issue;
  logic [1:0] finish;
  logic [1:0] own_c;
  logic [1:0] own_l;
  logic       proto_err;

  assign full  = count == (PW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign job.job_ready = !full;
  assign push  = job.job_valid && !full;
  assign pop   = |issue;
  assign head  = mem[rd_ptr];

  assign fin        = {load_finished, comp_finished};
  assign res_hit[0] = comp_lock_res[bk[0]];
  assign res_hit[1] = load_lock_res[bk[1]];
  assign finish[0]  = st[0] == S_RUN && fin[0];
  assign finish[1]  = st[1] == S_RUN && fin[1];

  assign comp_lock_req = req_q[0];
  assign load_lock_req = req_q[1];
  assign A_addr        = a_q[0];
  assign b_addr        = a_q[1];
  assign D_addr        = d_q;
  assign C_addr        = c_q;

  assign idle = empty && st[0] == S_IDLE
             && st[1] == S_IDLE;

  // Issue only the head job; a bank held by the other channel blocks all.
  always_comb begin
    issue    = '0;
    issue[0] = !empty && !head.is_load
            && st[0] == S_IDLE
            && !(st[1] != S_IDLE && bk[1] == head.bank);
    issue[1] = !empty && head.is_load
            && st[1] == S_IDLE
            && !(st[0] != S_IDLE && bk[0] == head.bank);
  end

  // A grant is legitimate only on the bank a channel currently owns.
  always_comb begin
    own_c = '0;
    own_l = '0;
    if (st[0] != S_IDLE) own_c[bk[0]] = 1'b1;
    if (st[1] != S_IDLE) own_l[bk[1]] = 1'b1;
    proto_err = (fin[0] && st[0] != S_RUN)
             || (fin[1] && st[1] != S_RUN)
             || |(comp_lock_res & ~own_c)
             || |(load_lock_res & ~own_l);
  end

  // FIFO storage, no reset needed for the payload.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{
        is_load: job.job_is_load,
        bank:    job.job_bank,
        a0:      job.job_addr0,
        a1:      job.job_addr1,
        a2:      job.job_addr2
      };
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Per-channel lock FSMs with registered requests and addresses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        st[c]    <= S_IDLE;
        bk[c]    <= 1'b0;
        cnt[c]   <= '0;
        req_q[c] <= '0;
        a_q[c]   <= '0;
      end
      d_q          <= '0;
      c_q          <= '0;
      done_count   <= '0;
      err_protocol <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        unique case (st[c])
          S_IDLE: begin
            if (issue[c]) begin
              st[c]  <= S_REQ;
              bk[c]  <= head.bank;
              cnt[c] <= '0;
              a_q[c] <= '0;
              a_q[c][head.bank] <= head.a0;
              if (c == 0) begin
                d_q <= '0;
                c_q <= '0;
                d_q[head.bank] <= head.a1;
                c_q[head.bank] <= head.a2;
              end
            end
          end
          S_REQ: begin
            req_q[c][bk[c]] <= 1'b1;
            if (res_hit[c]) begin
              st[c] <= S_RUN;
            end else if (cnt[c] != CW'(GRANT_TIMEOUT)) begin
              cnt[c] <= cnt[c] + 1'b1;
              if (CW'(cnt[c] + 1'b1) == CW'(GRANT_TIMEOUT))
                err_timeout <= 1'b1;
            end
          end
          S_RUN: begin
            if (fin[c]) begin
              st[c]    <= S_REL;
              req_q[c] <= '0;
            end
          end
          S_REL: begin
            if (!res_hit[c]) begin
              st[c]  <= S_IDLE;
              a_q[c] <= '0;
              if (c == 0) begin
                d_q <= '0;
                c_q <= '0;
              end
            end
          end
          default: st[c] <= S_IDLE;
        endcase
      end
      done_count <= done_count
                  + 16'(finish[0])
                  + 16'(finish[1]);
      if (proto_err) err_protocol <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sys_array_job_dispatcher.sv
// Directed bench for the job dispatcher: latency, concurrency,
// bank blocking, backpressure, timeout, protocol error, reset.
module tb_sys_array_job_dispatcher;

  logic             clk;
  logic             rst_n;
  logic [1:0]       comp_lock_req;
  logic [1:0][15:0] A_addr;
  logic [1:0][15:0] D_addr;
  logic [1:0][15:0] C_addr;
  logic [1:0]       comp_lock_res;
  logic             comp_finished;
  logic [1:0]       load_lock_req;
  logic [1:0][15:0] b_addr;
  logic [1:0]       load_lock_res;
  logic             load_finished;
  logic             idle;
  logic [15:0]      done_count;
  logic             err_protocol;
  logic             err_timeout;

  int n_chk;
  int n_err;

  sys_array_job_dispatcher_if jif ();

  sys_array_job_dispatcher dut (
    .clock         (clk),
    .reset         (rst_n),
    .job           (jif),
    .comp_lock_req (comp_lock_req),
    .A_addr        (A_addr),
    .D_addr        (D_addr),
    .C_addr        (C_addr),
    .comp_lock_res (comp_lock_res),
    .comp_finished (comp_finished),
    .load_lock_req (load_lock_req),
    .b_addr        (b_addr),
    .load_lock_res (load_lock_res),
    .load_finished (load_finished),
    .idle          (idle),
    .done_count    (done_count),
    .err_protocol  (err_protocol),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ld, input logic bank,
                      input logic [15:0] a0,
                      input logic [15:0] a1,
                      input logic [15:0] a2);
    jif.job_is_load = ld;
    jif.job_bank    = bank;
    jif.job_addr0   = a0;
    jif.job_addr1   = a1;
    jif.job_addr2   = a2;
    jif.job_valid   = 1'b1;
    tick();
    jif.job_valid   = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    jif.job_valid   = 1'b0;
    jif.job_is_load = 1'b0;
    jif.job_bank    = 1'b0;
    jif.job_addr0   = '0;
    jif.job_addr1   = '0;
    jif.job_addr2   = '0;
    comp_lock_res = '0;
    load_lock_res = '0;
    comp_finished = 1'b0;
    load_finished = 1'b0;
    tick();
    tick();
    chk("rst_creq", 32'(comp_lock_req), 0);
    chk("rst_lreq", 32'(load_lock_req), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_rdy", 32'(jif.job_ready), 1);
    chk("rst_done", 32'(done_count), 0);
    chk("rst_errs", 32'({err_protocol, err_timeout}), 0);
    chk("rst_A", 32'(A_addr), 0);
    rst_n = 1'b1;
    tick();

    // 1: single comp job, latency and addresses
    push(1'b0, 1'b0, 16'h10, 16'h20, 16'h30);
    chk("t1_busy", 32'(idle), 0);
    tick();
    chk("t1_req_t1", 32'(comp_lock_req), 0);
    tick();
    chk("t1_req_t2", 32'(comp_lock_req), 1);
    chk("t1_A0", 32'(A_addr[0]), 32'h10);
    chk("t1_D0", 32'(D_addr[0]), 32'h20);
    chk("t1_C0", 32'(C_addr[0]), 32'h30);
    chk("t1_A1", 32'(A_addr[1]), 0);
    tick();
    tick();
    comp_lock_res = 2'b01;
    tick();
    tick();
    comp_finished = 1'b1;
    chk("t1_req_fin", 32'(comp_lock_req), 1);
    tick();
    comp_finished = 1'b0;
    chk("t1_req_drop", 32'(comp_lock_req), 0);
    chk("t1_done", 32'(done_count), 1);
    chk("t1_rel_busy", 32'(idle), 0);
    comp_lock_res = 2'b00;
    tick();
    chk("t1_idle", 32'(idle), 1);
    chk("t1_A_clr", 32'(A_addr), 0);
    chk("t1_perr", 32'(err_protocol), 0);

    // 2: comp b0 and load b1 concurrently
    push(1'b0, 1'b0, 16'h100, 16'h200, 16'h300);
    push(1'b1, 1'b1, 16'h400, 16'h0, 16'h0);
    tick();
    chk("t2_creq", 32'(comp_lock_req), 1);
    tick();
    chk("t2_lreq", 32'(load_lock_req), 2);
    chk("t2_creq2", 32'(comp_lock_req), 1);
    chk("t2_b1", 32'(b_addr[1]), 32'h400);
    comp_lock_res = 2'b01;
    load_lock_res = 2'b10;
    tick();
    load_finished = 1'b1;
    tick();
    load_finished = 1'b0;
    chk("t2_done_l", 32'(done_count), 2);
    chk("t2_lreq_off", 32'(load_lock_req), 0);
    chk("t2_creq_on", 32'(comp_lock_req), 1);
    load_lock_res = 2'b00;
    comp_finished = 1'b1;
    tick();
    comp_finished = 1'b0;
    chk("t2_done_c", 32'(done_count), 3);
    comp_lock_res = 2'b00;
    tick();
    chk("t2_idle", 32'(idle), 1);
    chk("t2_perr", 32'(err_protocol), 0);

    // 3: load on same bank waits for comp release
    push(1'b0, 1'b0, 16'h11, 16'h22, 16'h33);
    push(1'b1, 1'b0, 16'h44, 16'h0, 16'h0);
    tick();
    tick();
    chk("t3_creq", 32'(comp_lock_req), 1);
    chk("t3_lblk0", 32'(load_lock_req), 0);
    comp_lock_res = 2'b01;
    tick();
    tick();
    tick();
    chk("t3_lblk1", 32'(load_lock_req), 0);
    comp_finished = 1'b1;
    tick();
    comp_finished = 1'b0;
    chk("t3_lblk2", 32'(load_lock_req), 0);
    comp_lock_res = 2'b00;
    tick();
    chk("t3_lblk3", 32'(load_lock_req), 0);
    tick();
    chk("t3_lblk4", 32'(load_lock_req), 0);
    tick();
    chk("t3_lreq", 32'(load_lock_req), 1);
    chk("t3_b0", 32'(b_addr[0]), 32'h44);
    load_lock_res = 2'b01;
    tick();
    load_finished = 1'b1;
    tick();
    load_finished = 1'b0;
    load_lock_res = 2'b00;
    tick();
    chk("t3_done", 32'(done_count), 5);
    chk("t3_idle", 32'(idle), 1);
    chk("t3_perr", 32'(err_protocol), 0);

    // 5: finished while idle is a sticky protocol error
    comp_finished = 1'b1;
    tick();
    comp_finished = 1'b0;
    chk("t5_perr", 32'(err_protocol), 1);
    chk("t5_done", 32'(done_count), 5);
    tick();
    tick();
    chk("t5_sticky", 32'(err_protocol), 1);

    // 4: backpressure and grant timeout
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("t4_rdy_3", 32'(jif.job_ready), 1);
      push(1'b0, 1'(i), 16'(16'h500 + i), 16'h0, 16'h0);
    end
    chk("t4_full", 32'(jif.job_ready), 0);
    for (int i = 0; i < 200; i++) tick();
    chk("t4_no_to", 32'(err_timeout), 0);
    for (int i = 0; i < 60; i++) tick();
    chk("t4_to", 32'(err_timeout), 1);
    chk("t4_req_held", 32'(comp_lock_req), 1);
    chk("t4_A0", 32'(A_addr[0]), 32'h500);
    comp_lock_res = 2'b01;
    tick();
    comp_finished = 1'b1;
    tick();
    comp_finished = 1'b0;
    comp_lock_res = 2'b00;
    tick();
    chk("t4_done", 32'(done_count), 6);
    chk("t4_to_sticky", 32'(err_timeout), 1);

    // 6: reset in RUN clears everything on the next edge
    tick();
    tick();
    chk("t6_creq", 32'(comp_lock_req), 2);
    chk("t6_A1", 32'(A_addr[1]), 32'h501);
    comp_lock_res = 2'b10;
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6_creq0", 32'(comp_lock_req), 0);
    chk("t6_addr0", 32'(A_addr), 0);
    chk("t6_done0", 32'(done_count), 0);
    chk("t6_idle", 32'(idle), 1);
    chk("t6_rdy", 32'(jif.job_ready), 1);
    chk("t6_errs", 32'({err_protocol, err_timeout}), 0);
    comp_lock_res = 2'b00;
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_empty", 32'(idle), 1);
    chk("t6_noreq", 32'(comp_lock_req), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
